// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_pkg
// Purpose : Shared core types: memory access width codes and LSU FSM states.
// Rev     : 1.0
// ============================================================================
package riscv_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_width_e;

  typedef enum logic [1:0] {
    LSU_IDLE      = 2'd0,
    LSU_BUS       = 2'd1,
    LSU_WAIT_DATA = 2'd2,
    LSU_RESP      = 2'd3
  } lsu_state_e;

  // Unsigned widths only exist for loads.
  function automatic logic funct3_illegal(input logic is_store, input logic [2:0] funct3);
    case (funct3)
      3'b011, 3'b110, 3'b111: return 1'b1;
      3'b100, 3'b101:         return is_store;
      default:                return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/avalon_mm_rw_if.sv
`default_nettype none
// ============================================================================
// Module  : AvalonMmRw
// Purpose : 32-bit Avalon-MM read/write data bus between a host and an agent.
// Rev     : 1.0
// ============================================================================
interface AvalonMmRw #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              read;
  logic              write;
  logic [31:0]       host_to_agent;
  logic [31:0]       agent_to_host;
  logic              waitrequest;
  logic              readdatavalid;

  modport Host (
    output address, byteenable, read, write, host_to_agent,
    input  agent_to_host, waitrequest, readdatavalid
  );

  modport Agent (
    input  address, byteenable, read, write, host_to_agent,
    output agent_to_host, waitrequest, readdatavalid
  );
endinterface
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_lane_align
// Purpose : Byte-lane mask, store data replication, load extraction, misalign.
// Rev     : 1.0
// ============================================================================
module lsu_lane_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byteenable,
  output logic [31:0] wdata_placed,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [31:0] lane;

  always_comb begin
    lane         = rdata >> {off, 3'b000};
    byteenable   = 4'b1111;
    wdata_placed = wdata;
    rdata_ext    = lane;
    misalign     = 1'b0;
    case (funct3)
      MEM_B: begin
        byteenable   = 4'b0001 << off;
        wdata_placed = {4{wdata[7:0]}};
        rdata_ext    = {{24{lane[7]}}, lane[7:0]};
      end
      MEM_BU: begin
        byteenable   = 4'b0001 << off;
        wdata_placed = {4{wdata[7:0]}};
        rdata_ext    = {24'd0, lane[7:0]};
      end
      MEM_H: begin
        byteenable   = 4'b0011 << off;
        wdata_placed = {2{wdata[15:0]}};
        rdata_ext    = {{16{lane[15]}}, lane[15:0]};
        misalign     = off[0];
      end
      MEM_HU: begin
        byteenable   = 4'b0011 << off;
        wdata_placed = {2{wdata[15:0]}};
        rdata_ext    = {16'd0, lane[15:0]};
        misalign     = off[0];
      end
      MEM_W: begin
        misalign     = (off != 2'b00);
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit
// Purpose : Single-outstanding load/store stage driving an Avalon-MM data bus.
// Rev     : 1.0
// ============================================================================
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_error,
  output logic [31:0]       rsp_rdata,
  AvalonMmRw.Host           dbus
);

  lsu_state_e        state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [3:0]        byteenable_q, byteenable_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              read_q, read_d;
  logic              wr_cmd_q, wr_cmd_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_error_q, rsp_error_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic [2:0]  al_funct3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_misalign;

  // In IDLE the aligner decodes the incoming request; afterwards the latched one.
  assign al_funct3 = (state_q == LSU_IDLE) ? req_funct3    : funct3_q;
  assign al_off    = (state_q == LSU_IDLE) ? req_addr[1:0] : off_q;

  lsu_lane_align u_align (
    .funct3       (al_funct3),
    .off          (al_off),
    .wdata        (req_wdata),
    .rdata        (dbus.agent_to_host),
    .byteenable   (al_be),
    .wdata_placed (al_wdata),
    .rdata_ext    (al_rdata),
    .misalign     (al_misalign)
  );

  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    write_d      = write_q;
    address_d    = address_q;
    byteenable_d = byteenable_q;
    wdata_d      = wdata_q;
    read_d       = read_q;
    wr_cmd_d     = wr_cmd_q;
    rsp_valid_d  = 1'b0;
    rsp_error_d  = 1'b0;
    rsp_rdata_d  = 32'd0;
    case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          funct3_d = req_funct3;
          off_d    = req_addr[1:0];
          write_d  = req_write;
          if (al_misalign || funct3_illegal(req_write, req_funct3)) begin
            state_d     = LSU_RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else begin
            state_d      = LSU_BUS;
            address_d    = {req_addr[ADDR_W-1:2], 2'b00};
            byteenable_d = al_be;
            wdata_d      = req_write ? al_wdata : 32'd0;
            read_d       = ~req_write;
            wr_cmd_d     = req_write;
          end
        end
      end
      LSU_BUS: begin
        if (!dbus.waitrequest) begin
          read_d   = 1'b0;
          wr_cmd_d = 1'b0;
          if (write_q) begin
            state_d     = LSU_RESP;
            rsp_valid_d = 1'b1;
          end else if (dbus.readdatavalid) begin
            state_d     = LSU_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = al_rdata;
          end else begin
            state_d = LSU_WAIT_DATA;
          end
        end
      end
      LSU_WAIT_DATA: begin
        if (dbus.readdatavalid) begin
          state_d     = LSU_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = al_rdata;
        end
      end
      LSU_RESP: begin
        state_d = LSU_IDLE;
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= LSU_IDLE;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
      write_q      <= 1'b0;
      address_q    <= '0;
      byteenable_q <= 4'd0;
      wdata_q      <= 32'd0;
      read_q       <= 1'b0;
      wr_cmd_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_error_q  <= 1'b0;
      rsp_rdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      write_q      <= write_d;
      address_q    <= address_d;
      byteenable_q <= byteenable_d;
      wdata_q      <= wdata_d;
      read_q       <= read_d;
      wr_cmd_q     <= wr_cmd_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_error_q  <= rsp_error_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign req_ready          = (state_q == LSU_IDLE);
  assign rsp_valid          = rsp_valid_q;
  assign rsp_error          = rsp_error_q;
  assign rsp_rdata          = rsp_rdata_q;
  assign dbus.address       = address_q;
  assign dbus.byteenable    = byteenable_q;
  assign dbus.read          = read_q;
  assign dbus.write         = wr_cmd_q;
  assign dbus.host_to_agent = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_load_store_unit
// Purpose : Directed self-checking bench for load_store_unit.
// Rev     : 1.0
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_error;
  logic [31:0] rsp_rdata;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  AvalonMmRw #(.ADDR_W(32)) bus ();

  load_store_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_error  (rsp_error),
    .rsp_rdata  (rsp_rdata),
    .dbus       (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request; the agent stalls nwait cycles and returns rword in cycle rdv_cyc
  // (cycles counted from acceptance = 0). exp_cyc is the hand-computed rsp_valid cycle.
  task automatic run_req(input string nm, input logic w, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rword, input int nwait, input int rdv_cyc,
                         input int exp_cyc, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input logic [31:0] exp_rd, input logic exp_err);
    int          cmd_cnt = 0;
    int          rsp_cnt = 0;
    int          rsp_cyc = -1;
    logic        bad_cmd = 1'b0;
    logic        got_err = 1'b0;
    logic [31:0] got_rd  = 32'd0;
    logic        ready_after = 1'b0;
    @(negedge clk);
    check({nm, " ready_before"}, {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    bus.waitrequest   = 1'b0;
    bus.readdatavalid = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFC;
    req_wdata = 32'h5A5A_5A5A;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      bus.waitrequest   = (k <= nwait);
      bus.readdatavalid = (k == rdv_cyc);
      bus.agent_to_host = (k == rdv_cyc) ? rword : 32'hCCCC_CCCC;
      @(negedge clk);
      if (bus.read || bus.write) begin
        cmd_cnt++;
        if (bus.read === w || bus.write === !w || bus.address !== exp_addr ||
            bus.byteenable !== exp_be || (w && bus.host_to_agent !== exp_wd))
          bad_cmd = 1'b1;
      end
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_cyc = k;
        got_err = rsp_error;
        got_rd  = rsp_rdata;
      end
      if (k == exp_cyc + 1) ready_after = req_ready;
    end
    bus.waitrequest   = 1'b0;
    bus.readdatavalid = 1'b0;
    check({nm, " rsp_count"}, 32'(rsp_cnt), 32'd1);
    check({nm, " rsp_cycle"}, 32'(rsp_cyc), 32'(exp_cyc));
    check({nm, " rsp_error"}, {31'd0, got_err}, {31'd0, exp_err});
    check({nm, " rsp_rdata"}, got_rd, exp_rd);
    check({nm, " cmd_cycles"}, 32'(cmd_cnt), exp_err ? 32'd0 : 32'(nwait + 1));
    check({nm, " cmd_fields"}, {31'd0, bad_cmd}, 32'd0);
    check({nm, " ready_after"}, {31'd0, ready_after}, 32'd1);
  endtask

  initial begin
    int late_rsp;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    bus.waitrequest   = 1'b0;
    bus.readdatavalid = 1'b0;
    bus.agent_to_host = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset rsp", {29'd0, rsp_valid, rsp_error, bus.read}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset cmd_be", {26'd0, bus.write, bus.byteenable, 1'b0}, 32'd0);
    check("reset address", bus.address, 32'd0);
    check("reset host_to_agent", bus.host_to_agent, 32'd0);
    rst_n = 1'b1;

    //      name        w     f3      addr          wdata          rword          nw rdv cyc exp_addr     be       exp_wd         exp_rd         err
    run_req("SW",       1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0,         0, 0,  2, 32'h10, 4'b1111, 32'hDEAD_BEEF, 32'h0,         1'b0);
    run_req("LW",       1'b0, 3'b010, 32'h10, 32'h0,         32'hDEAD_BEEF, 0, 1,  2, 32'h10, 4'b1111, 32'h0,         32'hDEAD_BEEF, 1'b0);
    run_req("SB",       1'b1, 3'b000, 32'h13, 32'hFFFF_FF80, 32'h0,         0, 0,  2, 32'h10, 4'b1000, 32'h8080_8080, 32'h0,         1'b0);
    run_req("LB",       1'b0, 3'b000, 32'h13, 32'h0,         32'h8012_3456, 0, 1,  2, 32'h10, 4'b1000, 32'h0,         32'hFFFF_FF80, 1'b0);
    run_req("LBU",      1'b0, 3'b100, 32'h13, 32'h0,         32'h8012_3456, 0, 1,  2, 32'h10, 4'b1000, 32'h0,         32'h0000_0080, 1'b0);
    run_req("SH",       1'b1, 3'b001, 32'h22, 32'h1234_8001, 32'h0,         0, 0,  2, 32'h20, 4'b1100, 32'h8001_8001, 32'h0,         1'b0);
    run_req("LH",       1'b0, 3'b001, 32'h22, 32'h0,         32'h8001_5678, 0, 1,  2, 32'h20, 4'b1100, 32'h0,         32'hFFFF_8001, 1'b0);
    run_req("LHU",      1'b0, 3'b101, 32'h22, 32'h0,         32'h8001_5678, 0, 1,  2, 32'h20, 4'b1100, 32'h0,         32'h0000_8001, 1'b0);
    run_req("LB_pos",   1'b0, 3'b000, 32'h21, 32'h0,         32'h0000_7F00, 0, 1,  2, 32'h20, 4'b0010, 32'h0,         32'h0000_007F, 1'b0);
    run_req("LW_mis",   1'b0, 3'b010, 32'h11, 32'h0,         32'h0,         0, 0,  1, 32'h0,  4'b0000, 32'h0,         32'h0,         1'b1);
    run_req("SH_mis",   1'b1, 3'b001, 32'h13, 32'hFFFF,      32'h0,         0, 0,  1, 32'h0,  4'b0000, 32'h0,         32'h0,         1'b1);
    run_req("LD_f011",  1'b0, 3'b011, 32'h10, 32'h0,         32'h0,         0, 0,  1, 32'h0,  4'b0000, 32'h0,         32'h0,         1'b1);
    run_req("ST_f100",  1'b1, 3'b100, 32'h10, 32'h0,         32'h0,         0, 0,  1, 32'h0,  4'b0000, 32'h0,         32'h0,         1'b1);
    run_req("LW_wait",  1'b0, 3'b010, 32'h40, 32'h0,         32'h0BAD_F00D, 3, 6,  7, 32'h40, 4'b1111, 32'h0,         32'h0BAD_F00D, 1'b0);
    run_req("SW_wait",  1'b1, 3'b010, 32'h44, 32'h1357_9BDF, 32'h0,         2, 0,  4, 32'h44, 4'b1111, 32'h1357_9BDF, 32'h0,         1'b0);

    // Reset while waiting for read data: transaction abandoned, no response later.
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h30;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("wait_data read_low", {31'd0, bus.read}, 32'd0);
    check("wait_data busy", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort req_ready", {31'd0, req_ready}, 32'd1);
    check("abort cmd", {30'd0, bus.read, bus.write}, 32'd0);
    check("abort address", bus.address, 32'd0);
    late_rsp = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      bus.readdatavalid = (k == 0);
      bus.agent_to_host = 32'h1111_2222;
      @(negedge clk);
      if (rsp_valid) late_rsp++;
    end
    bus.readdatavalid = 1'b0;
    check("abort late_rdv_rsp", 32'(late_rsp), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
